pwm_peripheral: RTL

PWM_PERIPHERAL -- requirements
Module: pwm_peripheral

---
 rtl/pwm_peripheral.sv | 96 +++++++++
 1 files changed

// File: rtl/pwm_peripheral.sv
// 16-channel PWM peripheral: prescaler, shared 0..254 period counter, per-channel enable/PWM select.
// Optional build macro PWM_DUTY_SHADOW_EN makes duty updates take effect only at period boundaries.
module pwm_peripheral #(
    parameter int unsigned CLK_DIV = 3000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  en_reg_out_7_0,
    input  logic [7:0]  en_reg_out_15_8,
    input  logic [7:0]  en_reg_pwm_7_0,
    input  logic [7:0]  en_reg_pwm_15_8,
    input  logic [7:0]  pwm_duty_cycle,
    output logic [15:0] out,
    output logic        period_start
);

    localparam logic [15:0] PRESC_LAST = 16'(CLK_DIV - 1);
    localparam logic [7:0]  CNT_LAST   = 8'd254;

    logic [15:0] prescaler;
    logic        tick;
    logic [7:0]  pwm_cnt;
    logic [7:0]  pwm_cnt_next;
    logic        wrap;
    logic [7:0]  duty_active;
    logic [7:0]  duty_next;
    logic        pwm_sig;
    logic [15:0] en_out;
    logic [15:0] en_pwm;
    logic [15:0] out_next;

    assign tick = (prescaler == PRESC_LAST);
    assign wrap = tick && (pwm_cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            prescaler <= 16'd0;
        end else if (tick) begin
            prescaler <= 16'd0;
        end else begin
            prescaler <= prescaler + 16'd1;
        end
    end

    always_comb begin
        pwm_cnt_next = pwm_cnt;
        if (wrap) begin
            pwm_cnt_next = 8'd0;
        end else if (tick) begin
            pwm_cnt_next = pwm_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_cnt <= 8'd0;
        end else begin
            pwm_cnt <= pwm_cnt_next;
        end
    end

`ifdef PWM_DUTY_SHADOW_EN
    // Duty is captured on the wrap edge so a period never sees a mid-period change.
    always_ff @(posedge clk) begin
        if (rst) begin
            duty_active <= 8'd0;
        end else if (wrap) begin
            duty_active <= pwm_duty_cycle;
        end
    end

    assign duty_next = wrap ? pwm_duty_cycle : duty_active;
`else
    assign duty_active = pwm_duty_cycle;
    assign duty_next   = duty_active;
`endif

    // Compare against the values the counter and duty hold next cycle, so the
    // registered output lines up with pwm_cnt and with period_start.
    assign pwm_sig = (duty_next == 8'hFF) || (pwm_cnt_next < duty_next);

    assign en_out   = {en_reg_out_15_8, en_reg_out_7_0};
    assign en_pwm   = {en_reg_pwm_15_8, en_reg_pwm_7_0};
    assign out_next = en_out & (~en_pwm | {16{pwm_sig}});

    always_ff @(posedge clk) begin
        if (rst) begin
            out          <= 16'h0000;
            period_start <= 1'b0;
        end else begin
            out          <= out_next;
            period_start <= wrap;
        end
    end

endmodule
